dual_port_bram: RTL and testbench

//   True dual-port synchronous block RAM with per-byte write strobes and a selectable write mode.

---
 rtl/bram_pkg.sv | 30 +++
 rtl/bram_port.sv | 64 ++++++
 rtl/dual_port_bram.sv | 91 +++++++++
 tb/tb_dual_port_bram.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
// Write-mode decoding and strobe-lane count.
package bram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST,
    WRITE_FIRST,
    NO_CHANGE
  } write_mode_e;

  function automatic int nstrb(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic bit mode_ok(input string s);
    return (s == "read_first") ||
           (s == "write_first") ||
           (s == "no_change");
  endfunction

  function automatic write_mode_e mode_of(input string s);
    if (s == "write_first")
      return WRITE_FIRST;
    else if (s == "no_change")
      return NO_CHANGE;
    else
      return READ_FIRST;
  endfunction

endpackage

// File: rtl/bram_port.sv
// One RAM port: strobe merge, write-mode output select, output regs.
// BRAM_OUTPUT_REG_EN adds a second, always-loading output stage.
module bram_port
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter write_mode_e MODE = READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int NSTRB = nstrb(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [NSTRB-1:0]      write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] q1;

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < NSTRB; b++) begin
      if (write_en[b])
        merged[b*BYTE_WIDTH +: BYTE_WIDTH] =
          data_in[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      q1 <= RESET_VALUE;
    end else if (en) begin
      unique case (MODE)
        READ_FIRST:  q1 <= rd_word;
        WRITE_FIRST: q1 <= merged;
        NO_CHANGE: begin
          if (!(|write_en))
            q1 <= rd_word;
        end
        default:     q1 <= rd_word;
      endcase
    end
  end

`ifdef BRAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] q2;

  always_ff @(posedge clk) begin
    if (resetn)
      q2 <= RESET_VALUE;
    else
      q2 <= q1;
  end

  assign data_out = q2;
`else
  assign data_out = q1;
`endif

endmodule

// File: rtl/dual_port_bram.sv
// True dual-port RAM with byte strobes and selectable same-port write mode.
// Optional BRAM_OUTPUT_REG_EN macro adds one extra output register stage.
module dual_port_bram
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int BYTE_WIDTH = 8,
  parameter string WRITE_MODE = "read_first",
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int NSTRB = nstrb(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en_1,
  input  logic [NSTRB-1:0]      write_en_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  output logic [DATA_WIDTH-1:0] data_out_1,
  input  logic                  en_2,
  input  logic [NSTRB-1:0]      write_en_2,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [DATA_WIDTH-1:0] data_out_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam write_mode_e MODE = mode_of(WRITE_MODE);

  if (!mode_ok(WRITE_MODE)) begin : g_bad_mode
    $fatal(1, "dual_port_bram: unknown WRITE_MODE");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_1;
  logic [DATA_WIDTH-1:0] rd_2;

  assign rd_1 = mem[addr_1];
  assign rd_2 = mem[addr_2];

  // Port 2 lanes are written last so they win on a same-lane collision.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (en_1) begin
        for (int b = 0; b < NSTRB; b++) begin
          if (write_en_1[b])
            mem[addr_1][b*BYTE_WIDTH +: BYTE_WIDTH] <=
              data_in_1[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (en_2) begin
        for (int b = 0; b < NSTRB; b++) begin
          if (write_en_2[b])
            mem[addr_2][b*BYTE_WIDTH +: BYTE_WIDTH] <=
              data_in_2[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  bram_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .MODE        (MODE),
    .RESET_VALUE (RESET_VALUE)
  ) u_port_1 (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en_1),
    .write_en (write_en_1),
    .data_in  (data_in_1),
    .rd_word  (rd_1),
    .data_out (data_out_1)
  );

  bram_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .MODE        (MODE),
    .RESET_VALUE (RESET_VALUE)
  ) u_port_2 (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en_2),
    .write_en (write_en_2),
    .data_in  (data_in_2),
    .rd_word  (rd_2),
    .data_out (data_out_2)
  );

endmodule

// File: tb/tb_dual_port_bram.sv
// Scoreboard bench: three RAMs (read_first/write_first/no_change) on one stimulus.
// Expected words are queued at issue and popped when the read latency elapses.
module tb_dual_port_bram;

  localparam logic [63:0] RV = 64'hDEAD_BEEF_0000_0001;
`ifdef BRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        en;
    logic [7:0]  we;
    logic [11:0] addr;
    logic [63:0] din;
    logic        chk;
    logic [63:0] xrf;
    logic [63:0] xwf;
    logic [63:0] xnc;
  } pst_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en_1 = 1'b0, en_2 = 1'b0;
  logic [7:0]  write_en_1 = '0, write_en_2 = '0;
  logic [11:0] addr_1 = '0, addr_2 = '0;
  logic [63:0] data_in_1 = '0, data_in_2 = '0;
  logic [63:0] do1 [3];
  logic [63:0] do2 [3];

  logic        chk_1 = 1'b0, chk_2 = 1'b0;
  logic [1:0]  pipe_1 = '0, pipe_2 = '0;
  logic [2:0][63:0] q1 [$];
  logic [2:0][63:0] q2 [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dual_port_bram #(
    .WRITE_MODE ("read_first"), .RESET_VALUE (RV)
  ) u_rf (
    .clk (clk), .resetn (resetn),
    .en_1 (en_1), .write_en_1 (write_en_1), .addr_1 (addr_1),
    .data_in_1 (data_in_1), .data_out_1 (do1[0]),
    .en_2 (en_2), .write_en_2 (write_en_2), .addr_2 (addr_2),
    .data_in_2 (data_in_2), .data_out_2 (do2[0])
  );

  dual_port_bram #(
    .WRITE_MODE ("write_first"), .RESET_VALUE (RV)
  ) u_wf (
    .clk (clk), .resetn (resetn),
    .en_1 (en_1), .write_en_1 (write_en_1), .addr_1 (addr_1),
    .data_in_1 (data_in_1), .data_out_1 (do1[1]),
    .en_2 (en_2), .write_en_2 (write_en_2), .addr_2 (addr_2),
    .data_in_2 (data_in_2), .data_out_2 (do2[1])
  );

  dual_port_bram #(
    .WRITE_MODE ("no_change"), .RESET_VALUE (RV)
  ) u_nc (
    .clk (clk), .resetn (resetn),
    .en_1 (en_1), .write_en_1 (write_en_1), .addr_1 (addr_1),
    .data_in_1 (data_in_1), .data_out_1 (do1[2]),
    .en_2 (en_2), .write_en_2 (write_en_2), .addr_2 (addr_2),
    .data_in_2 (data_in_2), .data_out_2 (do2[2])
  );

  always @(posedge clk) begin
    pipe_1 <= {pipe_1[0], chk_1};
    pipe_2 <= {pipe_2[0], chk_2};
  end

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected triple per port once its latency has elapsed.
  always @(negedge clk) begin
    logic [2:0][63:0] e;
    if (pipe_1[LAT-1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL p1_underflow: got empty queue want entry");
      end else begin
        e = q1.pop_front();
        cmp("p1_read_first",  do1[0], e[0]);
        cmp("p1_write_first", do1[1], e[1]);
        cmp("p1_no_change",   do1[2], e[2]);
      end
    end
    if (pipe_2[LAT-1]) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL p2_underflow: got empty queue want entry");
      end else begin
        e = q2.pop_front();
        cmp("p2_read_first",  do2[0], e[0]);
        cmp("p2_write_first", do2[1], e[1]);
        cmp("p2_no_change",   do2[2], e[2]);
      end
    end
  end

  function automatic pst_t idle();
    return '{default: '0};
  endfunction

  function automatic pst_t rd(input logic [11:0] a, input logic [63:0] x);
    return '{en: 1'b1, we: 8'h00, addr: a, din: 64'h0,
             chk: 1'b1, xrf: x, xwf: x, xnc: x};
  endfunction

  function automatic pst_t wr(input logic [7:0] w, input logic [11:0] a,
                              input logic [63:0] d);
    return '{en: 1'b1, we: w, addr: a, din: d,
             chk: 1'b0, xrf: 64'h0, xwf: 64'h0, xnc: 64'h0};
  endfunction

  function automatic pst_t wrc(input logic [7:0] w, input logic [11:0] a,
                               input logic [63:0] d, input logic [63:0] xr,
                               input logic [63:0] xw, input logic [63:0] xn);
    return '{en: 1'b1, we: w, addr: a, din: d,
             chk: 1'b1, xrf: xr, xwf: xw, xnc: xn};
  endfunction

  function automatic pst_t chk_only(input pst_t p, input logic [63:0] x);
    pst_t r = p;
    r.chk = 1'b1;
    r.xrf = x; r.xwf = x; r.xnc = x;
    return r;
  endfunction

  task automatic step(input logic rst, input pst_t p1, input pst_t p2);
    resetn     = rst;
    en_1       = p1.en;   en_2       = p2.en;
    write_en_1 = p1.we;   write_en_2 = p2.we;
    addr_1     = p1.addr; addr_2     = p2.addr;
    data_in_1  = p1.din;  data_in_2  = p2.din;
    chk_1      = p1.chk;  chk_2      = p2.chk;
    if (p1.chk) q1.push_back({p1.xnc, p1.xwf, p1.xrf});
    if (p2.chk) q2.push_back({p2.xnc, p2.xwf, p2.xrf});
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [63:0] A5 = 64'hAAAA_AAAA_3333_4444;

  initial begin
    @(negedge clk);
    // reset with enables off: outputs take RESET_VALUE
    step(1'b1, chk_only(idle(), RV), chk_only(idle(), RV));
    step(1'b1, chk_only(idle(), RV), chk_only(idle(), RV));
    // byte-strobe write over a full background word
    step(1'b0, idle(), wr(8'hFF, 12'd5, 64'hAAAA_AAAA_AAAA_AAAA));
    step(1'b0, idle(),
         wrc(8'h0F, 12'd5, 64'h1111_2222_3333_4444,
             64'hAAAA_AAAA_AAAA_AAAA, A5, RV));
    step(1'b0, rd(12'd5, A5), wr(8'hFF, 12'd9, 64'h77));
    // same-port read during write
    step(1'b0, wrc(8'hFF, 12'd9, 64'h55, 64'h77, 64'h55, A5), idle());
    step(1'b0, rd(12'd9, 64'h55), idle());
    // full-word collision: port 2 wins
    step(1'b0, wr(8'hFF, 12'd3, 64'h1), wr(8'hFF, 12'd3, 64'h2));
    step(1'b0, rd(12'd3, 64'h2), rd(12'd5, A5));
    // cross-port write vs read on one address
    step(1'b0, rd(12'd3, 64'h2),
         wrc(8'hFF, 12'd3, 64'h33, 64'h2, 64'h33, A5));
    step(1'b0, rd(12'd3, 64'h33), idle());
    // disabled port: strobes ignored, output held
    step(1'b0,
         '{en: 1'b0, we: 8'hFF, addr: 12'd3, din: 64'hFFFF, chk: 1'b1,
           xrf: 64'h33, xwf: 64'h33, xnc: 64'h33},
         idle());
    step(1'b0, rd(12'd3, 64'h33), idle());
    // partial-lane collision merge
    step(1'b0, wr(8'hFF, 12'd7, 64'h0), idle());
    step(1'b0,
         wrc(8'h0F, 12'd7, 64'h1111_1111_1111_1111,
             64'h0, 64'h0000_0000_1111_1111, 64'h33),
         wrc(8'h3C, 12'd7, 64'h2222_2222_2222_2222,
             64'h0, 64'h0000_2222_2222_0000, A5));
    step(1'b0, rd(12'd7, 64'h0000_2222_2222_1111), idle());
    // writes during reset are suppressed
    step(1'b1, chk_only(wr(8'hFF, 12'd9, 64'h99), RV),
         chk_only(idle(), RV));
    step(1'b0, rd(12'd9, 64'h55), rd(12'd7, 64'h0000_2222_2222_1111));
    for (int i = 0; i < LAT + 2; i++)
      step(1'b0, idle(), idle());
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
